stump_fetch_unit: RTL

Instruction fetch stage for the Stump processor, sitting directly upstream of the control block. Owns the program counter and the instruction register. On each fetch request it reads one 16-bit word from memory, latches it into `ir`, and advances the PC. The `ir` output feeds the control/decode logic, and `pc` feeds the datapath as the R7 view. Optional wait-state support lets the core run against memories slower than one cycle.

---
 rtl/stump_fetch_pkg.sv | 13 +
 rtl/stump_pc_reg.sv | 41 ++++
 rtl/stump_fetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/stump_fetch_pkg.sv
// Shared types and constants for the Stump instruction fetch stage.
package stump_fetch_pkg;

  localparam int STUMP_WORD_W = 16;

  localparam logic [STUMP_WORD_W-1:0] STUMP_RESET_PC = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

endpackage : stump_fetch_pkg

// File: rtl/stump_pc_reg.sv
// Stump program counter register: async active-low reset, load with
// priority over increment, increment computed from a selectable source.
module stump_pc_reg
  import stump_fetch_pkg::*;
#(
  parameter logic [STUMP_WORD_W-1:0] RESET_PC = STUMP_RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [STUMP_WORD_W-1:0] load_val_i,
  input  logic                    inc_i,
  input  logic [STUMP_WORD_W-1:0] inc_src_i,
  output logic [STUMP_WORD_W-1:0] pc_o
);

  logic [STUMP_WORD_W-1:0] pc_q;
  logic [STUMP_WORD_W-1:0] pc_d;

  // Next PC: load wins, otherwise source + 1 (wraps naturally at 16 bits).
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = inc_src_i + 16'h0001;
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : stump_pc_reg

// File: rtl/stump_fetch_unit.sv
// Stump instruction fetch stage: owns PC and IR, reads one word per fetch.
// Optional wait-state support is enabled by defining STUMP_MEM_WAIT_EN;
// without it every fetch completes in the request cycle and stall is 0.
//
//   state | meaning
//   IDLE  | no access outstanding; address driven straight from pc
//   WAIT  | access outstanding; address driven from the hold register
module stump_fetch_unit
  import stump_fetch_pkg::*;
#(
  parameter logic [STUMP_WORD_W-1:0] RESET_PC = STUMP_RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_req,
  input  logic                    pc_load,
  input  logic [STUMP_WORD_W-1:0] pc_in,
  input  logic [STUMP_WORD_W-1:0] mem_rdata,
  input  logic                    mem_ready,
  output logic [STUMP_WORD_W-1:0] mem_addr,
  output logic                    mem_ren,
  output logic [STUMP_WORD_W-1:0] ir,
  output logic [STUMP_WORD_W-1:0] pc,
  output logic                    ir_valid,
  output logic                    stall
);

  logic [STUMP_WORD_W-1:0] ir_q;
  logic                    ir_valid_q;
  logic                    complete;
  logic [STUMP_WORD_W-1:0] inc_src;

`ifdef STUMP_MEM_WAIT_EN
  fetch_state_e            state_q;
  logic [STUMP_WORD_W-1:0] hold_q;

  // Memory handshake: in WAIT the address comes from the hold register so a
  // PC load mid-access cannot disturb the outstanding read.
  always_comb begin
    mem_ren  = fetch_req;
    mem_addr = pc;
    inc_src  = pc;
    stall    = fetch_req & ~mem_ready;
    if (state_q == WAIT) begin
      mem_ren  = 1'b1;
      mem_addr = hold_q;
      inc_src  = hold_q;
      stall    = ~mem_ready;
    end
    complete = mem_ren & mem_ready;
  end

  // Fetch FSM with registered IR, valid pulse and address-hold register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hold_q     <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      ir_valid_q <= complete;
      if (complete) begin
        ir_q <= mem_rdata;
      end
      case (state_q)
        IDLE: begin
          hold_q <= pc;
          if (fetch_req && !mem_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;

  // Zero-wait memory: every request completes in the cycle it is made.
  always_comb begin
    mem_ren  = fetch_req;
    mem_addr = pc;
    inc_src  = pc;
    stall    = 1'b0;
    complete = fetch_req;
  end

  // Registered IR and valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      ir_valid_q <= complete;
      if (complete) begin
        ir_q <= mem_rdata;
      end
    end
  end
`endif

  stump_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .load_val_i (pc_in),
    .inc_i      (complete),
    .inc_src_i  (inc_src),
    .pc_o       (pc)
  );

  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;

endmodule : stump_fetch_unit
